conv2d_stream_engine: RTL and testbench

CONV2D_STREAM_ENGINE -- requirements
Module: conv2d_stream_engine

---
 rtl/conv2d_stream_engine_if.sv | 24 ++
 rtl/conv2d_stream_engine.sv | 218 +++++++++++++++++++++
 tb/tb_conv2d_stream_engine.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_stream_engine_if.sv
// Stream bundle for the convolution engine: a load stream carrying image then
// kernel words into the engine, and a result stream carrying sums back out.
interface conv2d_stream_engine_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv2d_stream_engine.sv
// Streaming 2-D convolution engine: loads an n x n image and a k x k kernel,
// then emits O x O windowed sums (stride s, implicit zero padding p), one
// multiply-accumulate per cycle, with an optional ReLU clamp on each result.
//
// state    | meaning
// IDLE     | waiting for start; config checked and latched here
// LOAD_IMG | accepting n*n image words, row-major
// LOAD_KER | accepting k*k kernel words, row-major
// COMPUTE  | one MAC per cycle; results handed out through a one-deep slot
// FINISH   | last result accepted; done pulses, then back to IDLE
module conv2d_stream_engine #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int MAX_N  = 16,
  parameter int MAX_K  = 5,
  parameter int DIM_W  = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [DIM_W-1:0]     cfg_n,
  input  logic [DIM_W-1:0]     cfg_k,
  input  logic [DIM_W-1:0]     cfg_s,
  input  logic [DIM_W-1:0]     cfg_p,
  input  logic                 cfg_relu,
  conv2d_stream_engine_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  // Coordinate width covers n*n word counts and padded coords plus a step.
  localparam int CW  = 2 * DIM_W + 1;
  localparam int IAW = (MAX_N * MAX_N > 1) ? $clog2(MAX_N * MAX_N) : 1;
  localparam int KAW = (MAX_K * MAX_K > 1) ? $clog2(MAX_K * MAX_K) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_IMG, LOAD_KER, COMPUTE, FINISH} state_t;

  state_t                   state;
  logic [DIM_W-1:0]         n_l, k_l, s_l, p_l;
  logic                     relu_l;
  logic [CW-1:0]            load_cnt;
  logic [CW-1:0]            orig_r, orig_c;
  logic [DIM_W-1:0]         kr, kc;
  logic [CW-1:0]            ker_idx;
  logic signed [ACC_W-1:0]  acc;
  logic                     all_issued;

  logic signed [DATA_W-1:0] img_mem [MAX_N*MAX_N];
  logic signed [DATA_W-1:0] ker_mem [MAX_K*MAX_K];

  logic                     cfg_bad, xfer;
  logic [CW-1:0]            img_words, ker_words, n2p;
  logic [CW-1:0]            pr, pc, ir, ic;
  logic                     row_in, col_in, last_term, last_col, last_row, slot_free;
  logic [IAW-1:0]           img_addr;
  logic signed [DATA_W-1:0] pix, coef;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  term, sum, result;

  assign cfg_bad = (cfg_n == '0) || (cfg_k == '0) || (cfg_s == '0) ||
                   (CW'(cfg_n) > CW'(MAX_N)) || (CW'(cfg_k) > CW'(MAX_K)) ||
                   (CW'(cfg_k) > CW'(cfg_n) + CW'({cfg_p, 1'b0}));

  assign xfer      = bus.in_valid && bus.in_ready;
  assign img_words = CW'(n_l) * CW'(n_l);
  assign ker_words = CW'(k_l) * CW'(k_l);
  assign n2p       = CW'(n_l) + CW'({p_l, 1'b0});

  // Padded-coordinate read: anything outside the stored image reads as zero.
  assign pr       = orig_r + CW'(kr);
  assign pc       = orig_c + CW'(kc);
  assign row_in   = (pr >= CW'(p_l)) && (pr < CW'(p_l) + CW'(n_l));
  assign col_in   = (pc >= CW'(p_l)) && (pc < CW'(p_l) + CW'(n_l));
  assign ir       = pr - CW'(p_l);
  assign ic       = pc - CW'(p_l);
  assign img_addr = IAW'(ir * CW'(n_l) + ic);
  assign pix      = (row_in && col_in) ? img_mem[img_addr] : '0;
  assign coef     = ker_mem[KAW'(ker_idx)];

  assign prod   = (2*DATA_W)'(pix) * (2*DATA_W)'(coef);
  assign term   = ACC_W'(prod);
  assign sum    = acc + term;
  assign result = (relu_l && sum[ACC_W-1]) ? '0 : sum;

  // A window is the last in its row/column when one more stride would overrun.
  assign last_term = (ker_idx == ker_words - CW'(1));
  assign last_col  = (orig_c + CW'(s_l) + CW'(k_l) > n2p);
  assign last_row  = (orig_r + CW'(s_l) + CW'(k_l) > n2p);
  assign slot_free = !bus.out_valid || bus.out_ready;

  // Buffer writes; contents are never cleared, each job rewrites what it uses.
  always_ff @(posedge CLK) begin
    if (xfer && state == LOAD_IMG) img_mem[IAW'(load_cnt)] <= bus.in_data;
    if (xfer && state == LOAD_KER) ker_mem[KAW'(load_cnt)] <= bus.in_data;
  end

  // Job sequencing, MAC datapath and the registered result slot.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      n_l           <= '0;
      k_l           <= '0;
      s_l           <= '0;
      p_l           <= '0;
      relu_l        <= 1'b0;
      load_cnt      <= '0;
      orig_r        <= '0;
      orig_c        <= '0;
      kr            <= '0;
      kc            <= '0;
      ker_idx       <= '0;
      acc           <= '0;
      all_issued    <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_l        <= cfg_n;
            k_l        <= cfg_k;
            s_l        <= cfg_s;
            p_l        <= cfg_p;
            relu_l     <= cfg_relu;
            load_cnt   <= '0;
            orig_r     <= '0;
            orig_c     <= '0;
            kr         <= '0;
            kc         <= '0;
            ker_idx    <= '0;
            acc        <= '0;
            all_issued <= 1'b0;
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              state        <= LOAD_IMG;
              busy         <= 1'b1;
              bus.in_ready <= 1'b1;
            end
          end
        end
        LOAD_IMG: begin
          if (xfer) begin
            if (load_cnt == img_words - CW'(1)) begin
              load_cnt <= '0;
              state    <= LOAD_KER;
            end else begin
              load_cnt <= load_cnt + CW'(1);
            end
          end
        end
        LOAD_KER: begin
          if (xfer) begin
            if (load_cnt == ker_words - CW'(1)) begin
              load_cnt     <= '0;
              state        <= COMPUTE;
              bus.in_ready <= 1'b0;
            end else begin
              load_cnt <= load_cnt + CW'(1);
            end
          end
        end
        COMPUTE: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            if (all_issued) begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
          if (!all_issued) begin
            if (!last_term) begin
              acc     <= sum;
              ker_idx <= ker_idx + CW'(1);
              if (kc == k_l - DIM_W'(1)) begin
                kc <= '0;
                kr <= kr + DIM_W'(1);
              end else begin
                kc <= kc + DIM_W'(1);
              end
            end else if (slot_free) begin
              // Final term folds straight into the slot; a busy slot freezes everything.
              bus.out_data  <= result;
              bus.out_valid <= 1'b1;
              bus.out_last  <= last_row && last_col;
              acc           <= '0;
              ker_idx       <= '0;
              kr            <= '0;
              kc            <= '0;
              if (last_col) begin
                orig_c <= '0;
                if (last_row) all_issued <= 1'b1;
                else          orig_r     <= orig_r + CW'(s_l);
              end else begin
                orig_c <= orig_c + CW'(s_l);
              end
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Self-checking bench for conv2d_stream_engine: directed vectors with known
// answers, stalled output, invalid configs, resets, and randomized jobs
// checked against a plain nested-loop convolution model.
module tb_conv2d_stream_engine;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam int MAX_N  = 16;
  localparam int MAX_K  = 5;
  localparam int DIM_W  = 6;

  logic             CLK = 1'b0;
  logic             RST;
  logic             start;
  logic [DIM_W-1:0] cfg_n, cfg_k, cfg_s, cfg_p;
  logic             cfg_relu;
  logic             busy, done, cfg_err;

  conv2d_stream_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  conv2d_stream_engine #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_N(MAX_N), .MAX_K(MAX_K), .DIM_W(DIM_W)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .cfg_n(cfg_n), .cfg_k(cfg_k), .cfg_s(cfg_s), .cfg_p(cfg_p), .cfg_relu(cfg_relu),
    .bus(bus), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  int     checks = 0;
  int     errors = 0;
  int     img_q[$];
  int     ker_q[$];
  longint exp_q[$];
  longint got_q[$];
  bit     got_last_q[$];
  int     viol, done_pulses, done_gap;
  bit     timed_out;
  logic   end_busy;

  // Reference: direct definition of a strided, zero-padded convolution.
  task automatic model(input int n, input int k, input int s, input int p, input bit relu);
    int o;
    longint a;
    exp_q.delete();
    o = (n + 2*p - k) / s + 1;
    for (int r = 0; r < o; r++)
      for (int c = 0; c < o; c++) begin
        a = 0;
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++) begin
            int y, x;
            y = r*s + i - p;
            x = c*s + j - p;
            if (y >= 0 && y < n && x >= 0 && x < n)
              a += longint'(img_q[y*n + x]) * longint'(ker_q[i*k + j]);
          end
        if (relu && a < 0) a = 0;
        exp_q.push_back(a);
      end
  endtask

  // Drives one job and records what came out; callers do the comparisons.
  task automatic run_job(input int n, input int k, input int s, input int p, input bit relu,
                         input int gap_pct, input int ready_pct, input int stall_first);
    int idx, cyc, last_hs, done_cyc, stalls, total;
    bit held;
    logic [ACC_W-1:0] held_d;
    logic held_l;
    idx = 0; cyc = 0; last_hs = -100; done_cyc = -1; stalls = 0; held = 0;
    held_d = '0; held_l = 1'b0;
    total = n*n + k*k;
    got_q.delete(); got_last_q.delete();
    viol = 0; done_pulses = 0; done_gap = -1; timed_out = 0;
    @(negedge CLK);
    cfg_n = DIM_W'(n); cfg_k = DIM_W'(k); cfg_s = DIM_W'(s); cfg_p = DIM_W'(p);
    cfg_relu = relu; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    while (cyc < 4000) begin
      if (done === 1'b1) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (held && (bus.out_valid !== 1'b1 || bus.out_data !== held_d || bus.out_last !== held_l))
        viol++;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      // Config inputs and start wiggle mid-job; the engine must ignore them.
      cfg_n = DIM_W'($urandom); cfg_k = DIM_W'($urandom);
      cfg_s = DIM_W'($urandom); cfg_p = DIM_W'($urandom); cfg_relu = 1'($urandom);
      start = (idx < total) ? 1'($urandom) : 1'b0;
      if (idx < total && $urandom_range(99) >= gap_pct) begin
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(idx < n*n ? img_q[idx] : ker_q[idx - n*n]);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = DATA_W'($urandom);
      end
      if (bus.in_valid && bus.in_ready) idx++;
      if (stall_first > 0 && got_q.size() == 0 && bus.out_valid === 1'b1) begin
        bus.out_ready = (stalls >= stall_first);
        if (stalls < stall_first) stalls++;
      end else begin
        bus.out_ready = ($urandom_range(99) < ready_pct);
      end
      held   = bus.out_valid && !bus.out_ready;
      held_d = bus.out_data;
      held_l = bus.out_last;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        got_q.push_back(longint'($signed(bus.out_data)));
        got_last_q.push_back(bus.out_last);
        last_hs = cyc;
      end
      @(negedge CLK);
      cyc++;
    end
    if (done_cyc < 0) timed_out = 1;
    else done_gap = done_cyc - last_hs;
    end_busy = busy;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    #1 RST = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_last, busy, done, cfg_err} !== 6'b0 || bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b last=%b busy=%b done=%b err=%b data=%0d, required all 0",
               bus.in_ready, bus.out_valid, bus.out_last, busy, done, cfg_err, bus.out_data);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_vectors;
    int n, k, s, p;
    bit relu;
    for (int t = 0; t < 6; t++) begin
      img_q.delete(); ker_q.delete(); exp_q.delete();
      n = 0; k = 0; s = 1; p = 0; relu = 0;
      case (t)
        0: begin n = 3; k = 2; for (int i = 1; i <= 9; i++) img_q.push_back(i);
                 ker_q = '{1, 0, 0, 1}; exp_q = '{6, 8, 12, 14}; end
        1: begin n = 2; k = 3; p = 1; img_q = '{1, 1, 1, 1};
                 for (int i = 0; i < 9; i++) ker_q.push_back(1); exp_q = '{4, 4, 4, 4}; end
        2: begin n = 4; k = 2; s = 2; for (int i = 0; i < 16; i++) img_q.push_back(i);
                 ker_q = '{1, 1, 1, 1}; exp_q = '{10, 18, 42, 50}; end
        3: begin n = 2; k = 1; relu = 1; img_q = '{1, -2, 3, -4}; ker_q = '{-1};
                 exp_q = '{0, 2, 0, 4}; end
        4: begin n = 2; k = 1; img_q = '{1, -2, 3, -4}; ker_q = '{-1};
                 exp_q = '{-1, 2, -3, 4}; end
        default: begin n = 2; k = 4; p = 1; img_q = '{1, 2, 3, 4};
                 for (int i = 0; i < 16; i++) ker_q.push_back(1); exp_q = '{10}; end
      endcase
      run_job(n, k, s, p, relu, 25, 75, 0);
      checks++;
      if (timed_out) begin errors++; $display("FAIL vec%0d timeout: done never seen", t); end
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL vec%0d count: got %0d results, expected %0d", t, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL vec%0d data[%0d]: got %0d expected %0d", t, i, got_q[i], exp_q[i]);
        end
        checks++;
        if (got_last_q[i] !== (i == exp_q.size() - 1)) begin
          errors++; $display("FAIL vec%0d last[%0d]: got %0b expected %0b", t, i, got_last_q[i], i == exp_q.size() - 1);
        end
      end
      checks++;
      if (done_pulses !== 1 || done_gap !== 1) begin
        errors++; $display("FAIL vec%0d done: pulses %0d gap %0d, expected 1 and 1", t, done_pulses, done_gap);
      end
      checks++;
      if (end_busy !== 1'b0) begin
        errors++; $display("FAIL vec%0d busy_after: got %b expected 0", t, end_busy);
      end
    end
  endtask

  task automatic test_stall;
    img_q.delete(); ker_q.delete();
    for (int i = 1; i <= 9; i++) img_q.push_back(i);
    ker_q = '{1, 0, 0, 1};
    exp_q = '{6, 8, 12, 14};
    run_job(3, 2, 1, 0, 0, 40, 100, 5);
    checks++;
    if (timed_out || got_q.size() != 4) begin
      errors++; $display("FAIL stall count: got %0d results (timeout %0b), expected 4", got_q.size(), timed_out);
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 3)) begin
        errors++; $display("FAIL stall data[%0d]: got %0d/%0b expected %0d/%0b", i, got_q[i], got_last_q[i], exp_q[i], i == 3);
      end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL stall stable: %0d changes while held, expected 0", viol); end
    checks++;
    if (done_gap !== 1 || done_pulses !== 1) begin
      errors++; $display("FAIL stall done: gap %0d pulses %0d, expected 1 and 1", done_gap, done_pulses);
    end
  endtask

  task automatic test_cfg_err;
    int bad[6][4] = '{'{2, 4, 1, 0}, '{0, 1, 1, 0}, '{3, 0, 1, 0},
                      '{3, 1, 0, 0}, '{17, 1, 1, 0}, '{6, 6, 1, 0}};
    int pulses, leaks;
    for (int t = 0; t < 6; t++) begin
      @(negedge CLK);
      cfg_n = DIM_W'(bad[t][0]); cfg_k = DIM_W'(bad[t][1]);
      cfg_s = DIM_W'(bad[t][2]); cfg_p = DIM_W'(bad[t][3]);
      cfg_relu = 1'b0; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg%0d err_pulse: got %b expected 1", t, cfg_err); end
      pulses = 0; leaks = 0;
      for (int c = 0; c < 4; c++) begin
        if (busy !== 1'b0 || bus.in_ready !== 1'b0) leaks++;
        @(negedge CLK);
        if (cfg_err === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0 || leaks !== 0) begin
        errors++; $display("FAIL cfg%0d after: extra pulses %0d busy/ready cycles %0d, expected 0 and 0", t, pulses, leaks);
      end
    end
  endtask

  task automatic test_reset_mid;
    int idx, cyc;
    bit seen;
    idx = 0; cyc = 0; seen = 0;
    img_q.delete(); ker_q.delete();
    for (int i = 1; i <= 9; i++) img_q.push_back(i);
    ker_q = '{1, 0, 0, 1};
    @(negedge CLK);
    cfg_n = 3; cfg_k = 2; cfg_s = 1; cfg_p = 0; cfg_relu = 0; start = 1'b1; bus.out_ready = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    while (cyc < 300 && !seen) begin
      if (bus.out_valid === 1'b1) seen = 1;
      else begin
        bus.in_valid = (idx < 13);
        bus.in_data  = DATA_W'(idx < 9 ? img_q[idx] : (idx < 13 ? ker_q[idx - 9] : 0));
        if (bus.in_valid && bus.in_ready) idx++;
        @(negedge CLK);
        cyc++;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!seen || bus.out_data !== ACC_W'(6)) begin
      errors++; $display("FAIL rstmid held: seen %0b data %0d, expected 1 and 6", seen, bus.out_data);
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_last, busy, done, cfg_err} !== 6'b0 || bus.out_data !== '0) begin
      errors++;
      $display("FAIL rstmid clear: ready=%b valid=%b last=%b busy=%b done=%b err=%b data=%0d, required all 0",
               bus.in_ready, bus.out_valid, bus.out_last, busy, done, cfg_err, bus.out_data);
    end
    @(negedge CLK);
    RST = 1'b0;
    cyc = 0;
    repeat (3) begin
      @(negedge CLK);
      if (bus.out_valid !== 1'b0 || busy !== 1'b0) cyc++;
    end
    checks++;
    if (cyc !== 0) begin errors++; $display("FAIL rstmid quiet: %0d active cycles, expected 0", cyc); end
    exp_q = '{6, 8, 12, 14};
    run_job(3, 2, 1, 0, 0, 10, 90, 0);
    checks++;
    if (timed_out || got_q.size() != 4) begin
      errors++; $display("FAIL rstmid rerun count: got %0d (timeout %0b), expected 4", got_q.size(), timed_out);
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rstmid rerun[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random;
    int n, k, s, p, kmax;
    bit relu;
    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(1, 6);
      p = $urandom_range(0, 2);
      kmax = (n + 2*p < MAX_K) ? n + 2*p : MAX_K;
      k = $urandom_range(1, kmax);
      s = $urandom_range(1, 3);
      relu = 1'($urandom);
      img_q.delete(); ker_q.delete();
      for (int i = 0; i < n*n; i++) img_q.push_back(int'($signed(16'($urandom))));
      for (int i = 0; i < k*k; i++) ker_q.push_back(int'($signed(16'($urandom))));
      model(n, k, s, p, relu);
      run_job(n, k, s, p, relu, 30, 60, 0);
      checks++;
      if (timed_out || got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d count: got %0d expected %0d (n%0d k%0d s%0d p%0d timeout %0b)",
                 t, got_q.size(), exp_q.size(), n, k, s, p, timed_out);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
          errors++;
          $display("FAIL rand%0d data[%0d]: got %0d/%0b expected %0d/%0b", t, i,
                   got_q[i], got_last_q[i], exp_q[i], i == exp_q.size() - 1);
        end
      end
      checks++;
      if (viol !== 0 || done_gap !== 1) begin
        errors++; $display("FAIL rand%0d stable/done: changes %0d gap %0d, expected 0 and 1", t, viol, done_gap);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    start = 1'b0; cfg_n = '0; cfg_k = '0; cfg_s = '0; cfg_p = '0; cfg_relu = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_stall();
    test_cfg_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
